demod_frame_ctrl: RTL

//  Sequencer for the 4-FSK symbol demodulator. Generates the one-clock symbol-boundary

---
 rtl/demod_frame_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/demod_frame_ctrl.sv
// 4-FSK demodulator sequencer: symbol strobe, sync hunt, length read and
// payload byte packing onto a valid/ready byte interface.
module demod_frame_ctrl #(
  parameter int          SYM_PERIOD = 128,
  parameter int          SAMPLE_DLY = 2,
  parameter logic [7:0]  SYNC_WORD  = 8'hD3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] sym_in,
  output logic       sym_strobe,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_start,
  output logic       frame_done,
  output logic       ovf_err,
  output logic [1:0] state
);

  // state | IDLE: disabled, HUNT: sync search, LEN: length byte, PAYLOAD: byte packing/drain
  typedef enum logic [1:0] {IDLE = 2'd0, HUNT = 2'd1, LEN = 2'd2, PAYLOAD = 2'd3} state_t;

  localparam int CW = ($clog2(SYM_PERIOD) > 8) ? $clog2(SYM_PERIOD) : 8;

  logic [CW-1:0]         cnt;
  logic [SAMPLE_DLY-1:0] dly, dly_nxt;
  logic                  tick;

  state_t     cur_state, nxt_state;
  logic [7:0] shreg, shreg_nxt, len, len_nxt, byte_cnt, byte_cnt_nxt;
  logic [7:0] byte_data_nxt, shifted;
  logic [1:0] sym_cnt, sym_cnt_nxt;
  logic       byte_valid_nxt, frame_start_nxt, frame_done_nxt, ovf_err_nxt;
  logic       accepted;

  assign sym_strobe = en && (cnt == CW'(SYM_PERIOD - 1));
  assign tick       = dly[SAMPLE_DLY-1];
  assign state      = cur_state;
  assign shifted    = {shreg[5:0], sym_in};
  assign accepted   = byte_valid && byte_ready;

  always_comb begin
    dly_nxt    = dly << 1;
    dly_nxt[0] = sym_strobe;
  end

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
      dly <= '0;
    end else begin
      cnt <= sym_strobe ? '0 : cnt + CW'(1);
      dly <= dly_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state   <= IDLE;
      shreg       <= '0;
      len         <= '0;
      byte_cnt    <= '0;
      sym_cnt     <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      shreg       <= shreg_nxt;
      len         <= len_nxt;
      byte_cnt    <= byte_cnt_nxt;
      sym_cnt     <= sym_cnt_nxt;
      byte_data   <= byte_data_nxt;
      byte_valid  <= byte_valid_nxt;
      frame_start <= frame_start_nxt;
      frame_done  <= frame_done_nxt;
      ovf_err     <= ovf_err_nxt;
    end
  end

  always_comb begin
    nxt_state       = cur_state;
    shreg_nxt       = shreg;
    len_nxt         = len;
    byte_cnt_nxt    = byte_cnt;
    sym_cnt_nxt     = sym_cnt;
    byte_data_nxt   = byte_data;
    byte_valid_nxt  = accepted ? 1'b0 : byte_valid;
    frame_start_nxt = 1'b0;
    frame_done_nxt  = 1'b0;
    ovf_err_nxt     = 1'b0;

    if (!en) begin
      nxt_state      = IDLE;
      shreg_nxt      = '0;
      len_nxt        = '0;
      byte_cnt_nxt   = '0;
      sym_cnt_nxt    = '0;
      byte_valid_nxt = 1'b0;
    end else begin
      case (cur_state)
        IDLE: nxt_state = HUNT;
        HUNT: begin
          if (tick) begin
            shreg_nxt = shifted;
            if (shifted == SYNC_WORD) begin
              frame_start_nxt = 1'b1;
              shreg_nxt       = '0;
              sym_cnt_nxt     = '0;
              nxt_state       = LEN;
            end
          end
        end
        LEN: begin
          if (tick) begin
            shreg_nxt   = shifted;
            sym_cnt_nxt = sym_cnt + 2'd1;
            if (sym_cnt == 2'd3) begin
              shreg_nxt = '0;
              if (shifted == 8'd0) begin
                nxt_state = HUNT;
              end else begin
                len_nxt      = shifted;
                byte_cnt_nxt = '0;
                nxt_state    = PAYLOAD;
              end
            end
          end
        end
        PAYLOAD: begin
          if (byte_cnt == len) begin
            // all bytes packed; only the last handshake remains
            if (accepted) begin
              frame_done_nxt = 1'b1;
              byte_cnt_nxt   = '0;
              nxt_state      = HUNT;
            end
          end else if (tick) begin
            shreg_nxt   = shifted;
            sym_cnt_nxt = sym_cnt + 2'd1;
            if (sym_cnt == 2'd3) begin
              shreg_nxt = '0;
              if (!byte_valid || accepted) begin
                byte_data_nxt  = shifted;
                byte_valid_nxt = 1'b1;
                byte_cnt_nxt   = byte_cnt + 8'd1;
              end else begin
                ovf_err_nxt    = 1'b1;
                byte_valid_nxt = 1'b0;
                byte_cnt_nxt   = '0;
                nxt_state      = HUNT;
              end
            end
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

endmodule
